// File: rtl/int_pkg.sv
// Shared constants for the interrupt controller: default MMIO map, vector base and
// the source numbering used by the SoC peripherals.
package int_pkg;
  localparam int          MAX_IRQ      = 8;
  localparam logic [15:0] ADDR_IE_DEF   = 16'hFFFF;
  localparam logic [15:0] ADDR_IF_DEF   = 16'hFF0F;
  localparam logic [15:0] ADDR_MODE_DEF = 16'hFF0E;
  localparam logic [15:0] VEC_BASE_DEF  = 16'h0040;
  localparam int          VEC_STRIDE_DEF = 8;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_LCDC   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_KEYPAD = 4;

  function automatic logic [15:0] vec_addr(input logic [15:0] base, input int stride,
                                           input logic [2:0] id);
    return base + 16'(id) * 16'(stride);
  endfunction
endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over up to eight request lines.
module int_prio_enc #(
  parameter int NUM_IRQ = 5
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_any,
  output logic [2:0]         o_id
);
  always_comb begin
    o_any = |i_req;
    o_id  = '0;
    // Scan downwards so the lowest set index is the last assignment.
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (i_req[i]) o_id = 3'(i);
  end
endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: IE/IF/MODE registers on the MMIO bus, per-source edge/level
// capture, fixed priority and an ack handshake that clears the serviced flag.
module int_ctrl
  import int_pkg::*;
#(
  parameter int          NUM_IRQ    = 5,
  parameter logic [15:0] ADDR_IE    = ADDR_IE_DEF,
  parameter logic [15:0] ADDR_IF    = ADDR_IF_DEF,
  parameter logic [15:0] ADDR_MODE  = ADDR_MODE_DEF,
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int          VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        a,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  input  logic               rd,
  input  logic               wr,
  output logic               sel,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_pending,
  output logic [2:0]         irq_id,
  output logic [15:0]        irq_vector,
  input  logic               irq_ack,
  output logic               irq_taken,
  output logic [2:0]         irq_taken_id
);
  logic [NUM_IRQ-1:0] r_ie, r_if, r_mode, r_sample;
  logic               r_pend, r_taken;
  logic [2:0]         r_id, r_tid;
  logic [15:0]        r_vec;

  logic               w_hit_ie, w_hit_if, w_hit_mode, w_ack_ok, w_any;
  logic [NUM_IRQ-1:0] w_set, w_ack_mask, w_if_next;
  logic [2:0]         w_id;
  logic [7:0]         w_rdata;
  logic [8:0]         w_unused;

  assign w_unused   = {rd, din};
  assign w_hit_ie   = (a == ADDR_IE);
  assign w_hit_if   = (a == ADDR_IF);
  assign w_hit_mode = (a == ADDR_MODE);
  assign sel        = w_hit_ie | w_hit_if | w_hit_mode;

  assign w_set      = (irq_in & ~r_sample & ~r_mode) | (irq_in & r_mode);
  assign w_ack_ok   = irq_ack & r_pend;
  assign w_ack_mask = NUM_IRQ'(1) << r_id;

  // Write-load, then ack-clear, then hardware set: a same-cycle request is never lost.
  always_comb begin
    w_if_next = (wr && w_hit_if) ? din[NUM_IRQ-1:0] : r_if;
    if (w_ack_ok) w_if_next = w_if_next & ~w_ack_mask;
    w_if_next = w_if_next | w_set;
  end

  int_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .i_req (r_ie & w_if_next),
    .o_any (w_any),
    .o_id  (w_id)
  );

  always_comb begin
    w_rdata = '0;
    if (w_hit_ie)        w_rdata[NUM_IRQ-1:0] = r_ie;
    else if (w_hit_if)   w_rdata[NUM_IRQ-1:0] = r_if | w_set;
    else if (w_hit_mode) w_rdata[NUM_IRQ-1:0] = r_mode;
  end
  assign dout = w_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie     <= '0;
      r_if     <= '0;
      r_mode   <= '0;
      r_sample <= '1;
      r_pend   <= 1'b0;
      r_id     <= '0;
      r_vec    <= VEC_BASE;
      r_taken  <= 1'b0;
      r_tid    <= '0;
    end else begin
      r_sample <= irq_in;
      r_if     <= w_if_next;
      if (wr && w_hit_ie)   r_ie   <= din[NUM_IRQ-1:0];
      if (wr && w_hit_mode) r_mode <= din[NUM_IRQ-1:0];
      r_pend  <= w_any;
      r_id    <= w_id;
      r_vec   <= vec_addr(VEC_BASE, VEC_STRIDE, w_id);
      r_taken <= w_ack_ok;
      if (w_ack_ok) r_tid <= r_id;
    end
  end

  assign irq_pending  = r_pend;
  assign irq_id       = r_id;
  assign irq_vector   = r_vec;
  assign irq_taken    = r_taken;
  assign irq_taken_id = r_tid;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed vector bench for int_ctrl: table of per-cycle stimulus with expected
// bus readback and registered outputs, plus a reset-during-ack sequence.
module tb_int_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  din, dout;
  logic        rd, wr, sel;
  logic [4:0]  irq_in;
  logic        irq_pending, irq_ack, irq_taken;
  logic [2:0]  irq_id, irq_taken_id;
  logic [15:0] irq_vector;

  int errors = 0;
  int checks = 0;

  int_ctrl dut (
    .clk(clk), .rst(rst), .a(a), .din(din), .dout(dout), .rd(rd), .wr(wr), .sel(sel),
    .irq_in(irq_in), .irq_pending(irq_pending), .irq_id(irq_id), .irq_vector(irq_vector),
    .irq_ack(irq_ack), .irq_taken(irq_taken), .irq_taken_id(irq_taken_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  din;
    logic        wr;
    logic [4:0]  irq;
    logic        ack;
    logic        e_sel;
    logic [7:0]  e_dout;
    logic        e_pend;
    logic [2:0]  e_id;
    logic [15:0] e_vec;
    logic        e_tk;
    logic [2:0]  e_tid;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a_, input logic [7:0] din_, input logic wr_,
                              input logic [4:0] irq_, input logic ack_, input logic sel_,
                              input logic [7:0] dout_, input logic pend_, input logic [2:0] id_,
                              input logic [15:0] vec_, input logic tk_, input logic [2:0] tid_);
    vec_t v;
    v.a = a_; v.din = din_; v.wr = wr_; v.irq = irq_; v.ack = ack_;
    v.e_sel = sel_; v.e_dout = dout_; v.e_pend = pend_; v.e_id = id_;
    v.e_vec = vec_; v.e_tk = tk_; v.e_tid = tid_;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [15:0] a_, input logic [7:0] d_,
                       input logic w_, input logic [4:0] i_, input logic k_);
    @(negedge clk);
    rst = r; a = a_; din = d_; wr = w_; rd = ~w_; irq_in = i_; irq_ack = k_;
  endtask

  task automatic chk_regs(input string tag, input logic pend_, input logic [2:0] id_,
                          input logic [15:0] vec_, input logic tk_, input logic [2:0] tid_);
    chk({tag, " pending"}, 16'(irq_pending), 16'(pend_));
    chk({tag, " id"}, 16'(irq_id), 16'(id_));
    chk({tag, " vector"}, irq_vector, vec_);
    chk({tag, " taken"}, 16'(irq_taken), 16'(tk_));
    if (tk_) chk({tag, " taken_id"}, 16'(irq_taken_id), 16'(tid_));
  endtask

  initial begin
    // a, din, wr, irq, ack | sel, dout | pend, id, vec, taken, taken_id
    tbl.push_back(mk(16'hFF0F, 8'h00, 0, 5'h1F, 0, 1, 8'h00, 0, 0, 16'h0040, 0, 0)); // high at release: no edge
    tbl.push_back(mk(16'hFFFF, 8'h00, 0, 5'h1F, 0, 1, 8'h00, 0, 0, 16'h0040, 0, 0));
    tbl.push_back(mk(16'hFFFF, 8'h1F, 1, 5'h00, 0, 1, 8'h00, 0, 0, 16'h0040, 0, 0)); // IE=1F
    tbl.push_back(mk(16'hFF0F, 8'h00, 0, 5'h04, 0, 1, 8'h04, 1, 2, 16'h0050, 0, 0)); // timer pulse
    tbl.push_back(mk(16'hFF0F, 8'h00, 0, 5'h00, 1, 1, 8'h04, 0, 0, 16'h0040, 1, 2)); // ack
    tbl.push_back(mk(16'hFF0F, 8'h00, 0, 5'h00, 0, 1, 8'h00, 0, 0, 16'h0040, 0, 0));
    tbl.push_back(mk(16'h0000, 8'h00, 0, 5'h13, 0, 0, 8'h00, 1, 0, 16'h0040, 0, 0)); // sources 0,1,4
    tbl.push_back(mk(16'h0000, 8'h00, 0, 5'h00, 1, 0, 8'h00, 1, 1, 16'h0048, 1, 0));
    tbl.push_back(mk(16'h0000, 8'h00, 0, 5'h00, 1, 0, 8'h00, 1, 4, 16'h0060, 1, 1));
    tbl.push_back(mk(16'h0000, 8'h00, 0, 5'h00, 1, 0, 8'h00, 0, 0, 16'h0040, 1, 4));
    tbl.push_back(mk(16'hFF0F, 8'h00, 0, 5'h00, 0, 1, 8'h00, 0, 0, 16'h0040, 0, 0));
    tbl.push_back(mk(16'hFF0F, 8'h00, 1, 5'h08, 0, 1, 8'h08, 1, 3, 16'h0058, 0, 0)); // set beats write-clear
    tbl.push_back(mk(16'hFF0F, 8'h00, 0, 5'h08, 0, 1, 8'h08, 1, 3, 16'h0058, 0, 0));
    tbl.push_back(mk(16'hFF0F, 8'h00, 1, 5'h00, 0, 1, 8'h08, 0, 0, 16'h0040, 0, 0)); // write-clear
    tbl.push_back(mk(16'hFF0E, 8'h01, 1, 5'h00, 0, 1, 8'h00, 0, 0, 16'h0040, 0, 0)); // MODE=01
    tbl.push_back(mk(16'hFFFF, 8'h01, 1, 5'h00, 0, 1, 8'h1F, 0, 0, 16'h0040, 0, 0)); // IE=01
    tbl.push_back(mk(16'hFF0E, 8'h00, 0, 5'h01, 0, 1, 8'h01, 1, 0, 16'h0040, 0, 0)); // level held
    tbl.push_back(mk(16'hFF0F, 8'h00, 0, 5'h01, 1, 1, 8'h01, 1, 0, 16'h0040, 1, 0)); // ack, re-set
    tbl.push_back(mk(16'hFF0F, 8'h00, 0, 5'h00, 1, 1, 8'h01, 0, 0, 16'h0040, 1, 0)); // dropped, ack
    tbl.push_back(mk(16'hFF0F, 8'h00, 0, 5'h00, 1, 1, 8'h00, 0, 0, 16'h0040, 0, 0)); // ack ignored
    tbl.push_back(mk(16'hFF0E, 8'h00, 1, 5'h00, 0, 1, 8'h01, 0, 0, 16'h0040, 0, 0)); // MODE=00
    tbl.push_back(mk(16'hFF0F, 8'h00, 0, 5'h01, 0, 1, 8'h01, 1, 0, 16'h0040, 0, 0)); // edge
    tbl.push_back(mk(16'hFF0F, 8'h00, 0, 5'h01, 1, 1, 8'h01, 0, 0, 16'h0040, 1, 0)); // held: no re-set
    tbl.push_back(mk(16'hFF0E, 8'h01, 1, 5'h01, 0, 1, 8'h00, 0, 0, 16'h0040, 0, 0)); // edge->level
    tbl.push_back(mk(16'hFF0F, 8'h00, 0, 5'h01, 0, 1, 8'h01, 1, 0, 16'h0040, 0, 0)); // sets next cycle

    // Reset with every line already high.
    drive(1, 16'h0000, 8'h00, 0, 5'h1F, 0);
    @(posedge clk);
    drive(1, 16'h0000, 8'h00, 0, 5'h1F, 0);
    @(posedge clk); #1;
    chk_regs("reset", 0, 0, 16'h0040, 0, 0);
    chk("reset taken_id", 16'(irq_taken_id), 16'h0);

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(0, tbl[i].a, tbl[i].din, tbl[i].wr, tbl[i].irq, tbl[i].ack);
      #1;
      chk({tag, " sel"}, 16'(sel), 16'(tbl[i].e_sel));
      chk({tag, " dout"}, 16'(dout), 16'(tbl[i].e_dout));
      @(posedge clk); #1;
      chk_regs(tag, tbl[i].e_pend, tbl[i].e_id, tbl[i].e_vec, tbl[i].e_tk, tbl[i].e_tid);
    end

    // Reset lands on the ack cycle of a pending level IRQ.
    chk("pre-rst pending", 16'(irq_pending), 16'h1);
    drive(1, 16'h0000, 8'h00, 0, 5'h01, 1);
    @(posedge clk); #1;
    chk_regs("rst-ack", 0, 0, 16'h0040, 0, 0);
    drive(0, 16'hFFFF, 8'h00, 0, 5'h00, 0);
    #1 chk("rst IE", 16'(dout), 16'h0);
    a = 16'hFF0F;
    #1 chk("rst IF", 16'(dout), 16'h0);
    a = 16'hFF0E;
    #1 chk("rst MODE", 16'(dout), 16'h0);
    @(posedge clk); #1;
    chk_regs("post-rst", 0, 0, 16'h0040, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
